// File: rtl/chan_llr_buffer.sv
// chan_llr_buffer: channel LLR input stage for the SC polar decoder.
// Wide channel LLRs are quantized (arithmetic shift plus symmetric clamp)
// and written into a two-bank ping-pong frame store. Full banks are read
// out in write order as (llr[i], llr[i+N/2]) pairs for the first f/g stage.
// Holding at the last pair replays the same frame.
module chan_llr_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH   = 16,
  parameter int N          = 1024,
  parameter int SHIFT      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IN_WIDTH-1:0]      in_llr,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    a,
  output logic [DATA_WIDTH-1:0]    b,
  output logic [$clog2(N)-2:0]     out_idx,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     hold,
  output logic                     sat_flag
);

  localparam int AW = $clog2(N);
  localparam int IW = AW - 1;

  // Per-bank state encoding; bit 1 set means the bank holds a complete frame.
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_READING = 2'd3;

  localparam logic signed [IN_WIDTH-1:0] MAX_T = IN_WIDTH'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [IN_WIDTH-1:0] MIN_T = -MAX_T;
  localparam logic [DATA_WIDTH-1:0]      MAX_Q = MAX_T[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0]      MIN_Q = MIN_T[DATA_WIDTH-1:0];
  localparam logic [IW-1:0]              LAST_IDX  = IW'(N/2 - 1);
  localparam logic [IW-1:0]              IDX_ONE   = IW'(1);
  localparam logic [AW-1:0]              LAST_WPTR = AW'(N - 1);
  localparam logic [AW-1:0]              WPTR_ONE  = AW'(1);

  // Returns {saturated, quantized}; the most-negative code is never produced.
  function automatic logic [DATA_WIDTH:0] quantize(input logic [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH-1:0] t;
    t = $signed(x) >>> SHIFT;
    if (t > MAX_T) begin
      return {1'b1, MAX_Q};
    end else if (t < MIN_T) begin
      return {1'b1, MIN_Q};
    end else begin
      return {1'b0, t[DATA_WIDTH-1:0]};
    end
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [2][N];
  logic [1:0]            st_r [2];
  logic [1:0]            st_nxt_s [2];
  logic [1:0]            sat_r, sat_nxt_s;
  logic                  wbank_r, wbank_nxt_s;
  logic                  rbank_r, rbank_nxt_s;
  logic [AW-1:0]         wptr_r, wptr_nxt_s;
  logic                  in_ready_r, in_ready_nxt_s;

  logic [DATA_WIDTH:0]   q_s;
  logic                  wr_s, wlast_s, take_s;
  logic                  hs_s, replay_s, release_s, ld_s;
  logic [IW-1:0]         ld_addr_s;
  logic [IW-1:0]         fidx_r;
  logic                  fetch_on_r;

  logic [DATA_WIDTH-1:0] a_r, b_r;
  logic [IW-1:0]         out_idx_r;
  logic                  out_last_r, out_valid_r, sat_flag_r;

  // Decode the per-cycle write, take, handshake and fetch events.
  always_comb begin
    q_s       = quantize(in_llr);
    wr_s      = in_valid & in_ready_r;
    wlast_s   = (wptr_r == LAST_WPTR);
    take_s    = (st_r[rbank_r] == ST_FULL);
    hs_s      = out_valid_r & out_ready;
    replay_s  = hs_s & out_last_r & hold;
    release_s = hs_s & out_last_r & ~hold;
    ld_s      = replay_s | (fetch_on_r & (~out_valid_r | out_ready));
    if (replay_s) begin
      ld_addr_s = {IW{1'b0}};
    end else begin
      ld_addr_s = fidx_r;
    end
  end

  // Bank state registers, pointers and the registered write-side ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r[0]    <= ST_EMPTY;
      st_r[1]    <= ST_EMPTY;
      sat_r      <= 2'b00;
      wbank_r    <= 1'b0;
      rbank_r    <= 1'b0;
      wptr_r     <= {AW{1'b0}};
      in_ready_r <= 1'b0;
    end else begin
      st_r       <= st_nxt_s;
      sat_r      <= sat_nxt_s;
      wbank_r    <= wbank_nxt_s;
      rbank_r    <= rbank_nxt_s;
      wptr_r     <= wptr_nxt_s;
      in_ready_r <= in_ready_nxt_s;
    end
  end

  // Next bank states: writes fill the write bank, reads take and release the read bank.
  always_comb begin
    st_nxt_s    = st_r;
    sat_nxt_s   = sat_r;
    wptr_nxt_s  = wptr_r;
    wbank_nxt_s = wbank_r;
    rbank_nxt_s = rbank_r;
    if (wr_s) begin
      case (st_r[wbank_r])
        ST_EMPTY, ST_FILLING: st_nxt_s[wbank_r] = wlast_s ? ST_FULL : ST_FILLING;
        default:              st_nxt_s[wbank_r] = st_r[wbank_r];
      endcase
      sat_nxt_s[wbank_r] = sat_r[wbank_r] | q_s[DATA_WIDTH];
      if (wlast_s) begin
        wptr_nxt_s  = {AW{1'b0}};
        wbank_nxt_s = ~wbank_r;
      end else begin
        wptr_nxt_s  = wptr_r + WPTR_ONE;
        wbank_nxt_s = wbank_r;
      end
    end else begin
      wptr_nxt_s  = wptr_r;
      wbank_nxt_s = wbank_r;
    end
    // A bank being taken is FULL and one being released is READING, so the
    // write above never targets the same bank as either of these.
    if (take_s) begin
      st_nxt_s[rbank_r] = ST_READING;
      rbank_nxt_s       = rbank_r;
    end else if (release_s) begin
      st_nxt_s[rbank_r]  = ST_EMPTY;
      sat_nxt_s[rbank_r] = 1'b0;
      rbank_nxt_s        = ~rbank_r;
    end else begin
      rbank_nxt_s = rbank_r;
    end
  end

  // Ready for the next cycle: the (possibly new) write bank has room.
  always_comb begin
    in_ready_nxt_s = ~st_nxt_s[wbank_nxt_s][1];
  end

  // Frame store write port; contents need no reset since bank state gates reads.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wbank_r][wptr_r] <= q_s[DATA_WIDTH-1:0];
    end
  end

  // Read side: registered memory read straight into the output pair register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= {DATA_WIDTH{1'b0}};
      b_r         <= {DATA_WIDTH{1'b0}};
      out_idx_r   <= {IW{1'b0}};
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      sat_flag_r  <= 1'b0;
      fidx_r      <= {IW{1'b0}};
      fetch_on_r  <= 1'b0;
    end else if (take_s) begin
      fidx_r     <= {IW{1'b0}};
      fetch_on_r <= 1'b1;
    end else if (ld_s) begin
      a_r         <= mem_r[rbank_r][{1'b0, ld_addr_s}];
      b_r         <= mem_r[rbank_r][{1'b1, ld_addr_s}];
      out_idx_r   <= ld_addr_s;
      out_last_r  <= (ld_addr_s == LAST_IDX);
      out_valid_r <= 1'b1;
      sat_flag_r  <= sat_r[rbank_r];
      fidx_r      <= ld_addr_s + IDX_ONE;
      fetch_on_r  <= (ld_addr_s != LAST_IDX);
    end else if (hs_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      sat_flag_r  <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign a         = a_r;
  assign b         = b_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;
  assign out_valid = out_valid_r;
  assign sat_flag  = sat_flag_r;

endmodule
